// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc core: datapath widths, opcode map and
// the fetch-stage state encoding.
package nrisc_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/nrisc_pc_reg.sv
// Program counter: load (branch redirect) has priority over increment;
// otherwise the value is held. Increment wraps at 2^ADDR_W.
module nrisc_pc_reg
    import nrisc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // PC update: redirect, step or hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/nrisc_fetch_unit.sv
// Instruction fetch stage: req/ready fetch from instruction memory, one
// registered instruction issued per fetch, branch redirect and sticky halt.
module nrisc_fetch_unit
    import nrisc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
    parameter logic [2:0]        HALT_OPCODE = OP_HALT
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic [DATA_W-1:0] instr,
    output logic [2:0]        func_code,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] w_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              w_capture;
    logic              w_accept;
    logic              w_stop;
    logic              w_load;
    logic              w_inc;

    // Halt wins over branch, branch wins over increment; pc is frozen on halt
    assign w_capture = (r_state == FETCH) && imem_ready;
    assign w_accept  = (r_state == ISSUE) && !stall;
    assign w_stop    = w_accept && (halt || (r_instr[DATA_W-1 -: 3] == HALT_OPCODE));
    assign w_load    = w_accept && !w_stop && branch_taken;
    assign w_inc     = w_accept && !w_stop && !branch_taken;

    nrisc_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (branch_target),
        .i_inc      (w_inc),
        .o_pc       (w_pc)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            ISSUE: begin
                if (w_stop) begin
                    w_next_state = HALTED;
                end else if (w_accept) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = ISSUE;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded purely from the state register
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = 1'b1;
            end
            ISSUE: begin
                instr_valid = 1'b1;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
                halted      = 1'b0;
            end
        endcase
    end

    // Instruction register, loaded only when memory answers a fetch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr    <= '0;
            r_instr_pc <= RESET_PC;
        end else if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= w_pc;
        end else begin
            r_instr    <= r_instr;
            r_instr_pc <= r_instr_pc;
        end
    end

    assign imem_addr = w_pc;
    assign instr     = r_instr;
    assign func_code = r_instr[DATA_W-1 -: 3];
    assign instr_pc  = r_instr_pc;

endmodule

// File: tb/tb_nrisc_fetch_unit.sv
// Self-checking bench for nrisc_fetch_unit: a bench-side pc model predicts
// each fetch address; fetched words go into a scoreboard checked at issue.
module tb_nrisc_fetch_unit;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       halt = 1'b0;
    logic [7:0] instr;
    logic [2:0] func_code;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       halted;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_item_t;

    sb_item_t   sb_q[$];
    logic [7:0] mem [256];
    logic [7:0] model_pc;
    logic       model_halted;
    int         n_checks = 0;
    int         n_errors = 0;

    nrisc_fetch_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .instr         (instr),
        .func_code     (func_code),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_req", imem_req, 32'd0);
        chk("rst_addr", imem_addr, 32'h00);
        chk("rst_instr", instr, 32'h00);
        chk("rst_func", func_code, 32'd0);
        chk("rst_ipc", instr_pc, 32'h00);
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_halted", halted, 32'd0);
        imem_ready    = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        halt          = 1'b0;
        model_pc      = 8'h00;
        model_halted  = 1'b0;
        sb_q.delete();
        tick();
        reset_n = 1'b1;
        chk("idle_req", imem_req, 32'd0);
        tick();
    endtask

    // One fetch (with optional memory wait) followed by its issue (with optional stall)
    task automatic fetch_issue(input int waits, input int stalls, input logic br,
                               input logic [7:0] tgt, input logic hlt);
        sb_item_t item;
        sb_item_t got;
        item.addr = model_pc;
        item.data = mem[model_pc];
        sb_q.push_back(item);
        for (int w = 0; w < waits; w++) begin
            chk("wait_req", imem_req, 32'd1);
            chk("wait_addr", imem_addr, item.addr);
            chk("wait_valid", instr_valid, 32'd0);
            imem_ready = 1'b0;
            imem_rdata = 8'hE0;
            tick();
        end
        chk("fetch_req", imem_req, 32'd1);
        chk("fetch_addr", imem_addr, item.addr);
        imem_ready = 1'b1;
        imem_rdata = item.data;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 8'hE0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            got = item;
        end else begin
            got = sb_q.pop_front();
        end
        chk("issue_valid", instr_valid, 32'd1);
        chk("issue_req", imem_req, 32'd0);
        chk("issue_instr", instr, got.data);
        chk("issue_func", func_code, got.data[7:5]);
        chk("issue_ipc", instr_pc, got.addr);
        for (int s = 0; s < stalls; s++) begin
            stall         = 1'b1;
            branch_taken  = br;
            branch_target = tgt;
            imem_ready    = 1'b1;
            tick();
            chk("stall_valid", instr_valid, 32'd1);
            chk("stall_instr", instr, got.data);
            chk("stall_ipc", instr_pc, got.addr);
            chk("stall_addr", imem_addr, got.addr);
            chk("stall_req", imem_req, 32'd0);
        end
        stall         = 1'b0;
        imem_ready    = 1'b0;
        branch_taken  = br;
        branch_target = tgt;
        halt          = hlt;
        tick();
        branch_taken = 1'b0;
        halt         = 1'b0;
        if (hlt || (got.data[7:5] == 3'b111)) begin
            model_halted = 1'b1;
        end else if (br) begin
            model_pc = tgt;
        end else begin
            model_pc = model_pc + 8'd1;
        end
        if (model_halted) begin
            chk("post_halted", halted, 32'd1);
            chk("post_hreq", imem_req, 32'd0);
            chk("post_hvalid", instr_valid, 32'd0);
            chk("post_haddr", imem_addr, model_pc);
        end else begin
            chk("post_req", imem_req, 32'd1);
            chk("post_addr", imem_addr, model_pc);
            chk("post_valid", instr_valid, 32'd0);
            chk("post_halted0", halted, 32'd0);
        end
    endtask

    task automatic halted_hold();
        for (int c = 0; c < 3; c++) begin
            imem_ready = 1'b1;
            imem_rdata = 8'h11;
            tick();
            chk("hold_halted", halted, 32'd1);
            chk("hold_req", imem_req, 32'd0);
            chk("hold_valid", instr_valid, 32'd0);
            chk("hold_addr", imem_addr, model_pc);
        end
        imem_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {1'b0, 7'($urandom)};
        end
        mem[8'h00] = 8'h01;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'h43;
        mem[8'h07] = 8'h64;
        mem[8'h20] = 8'hE0;
        model_pc     = 8'h00;
        model_halted = 1'b0;
        #3;
        do_reset();

        // In-order fetch with zero-wait memory, then branch held across a stall
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 2, 1'b1, 8'h40, 1'b0);
        fetch_issue(0, 0, 1'b1, 8'h05, 1'b0);
        fetch_issue(3, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 4, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 0, 1'b1, 8'hFF, 1'b0);
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 0, 1'b1, 8'h20, 1'b0);
        // HALT opcode beats a simultaneous branch
        fetch_issue(0, 0, 1'b1, 8'h30, 1'b0);
        halted_hold();

        // External halt together with branch
        do_reset();
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 0, 1'b1, 8'h50, 1'b1);
        halted_hold();

        // Reset while a fetch waits on memory
        do_reset();
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);
        chk("mid_req", imem_req, 32'd1);
        chk("mid_addr", imem_addr, 32'h02);
        tick();
        tick();
        do_reset();
        fetch_issue(0, 0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
